// File: rtl/bsv_credit_ctrl_if.sv
// Credit-pool control bundle between the requester/counter side and bsv_credit_ctrl.
// The controller sits on the slave modport; the environment drives the master side.
interface bsv_credit_ctrl_if #(
    parameter int unsigned width = 8
);
    logic             init_req;
    logic [width-1:0] init_value;
    logic             init_done;
    logic             ret_valid;
    logic [width-1:0] ret_amount;
    logic             cons_valid;
    logic [width-1:0] cons_amount;
    logic             cons_ready;
    logic [width-1:0] count_in;
    logic             cmd_adda;
    logic [width-1:0] cmd_data_a;
    logic             cmd_addb;
    logic [width-1:0] cmd_data_b;
    logic             cmd_setf;
    logic [width-1:0] cmd_data_f;
    logic             ret_dropped;
    logic             ovf_err;

    modport master (
        output init_req, init_value, ret_valid, ret_amount, cons_valid, cons_amount, count_in,
        input  init_done, cons_ready, cmd_adda, cmd_data_a, cmd_addb, cmd_data_b,
               cmd_setf, cmd_data_f, ret_dropped, ovf_err
    );

    modport slave (
        input  init_req, init_value, ret_valid, ret_amount, cons_valid, cons_amount, count_in,
        output init_done, cons_ready, cmd_adda, cmd_data_a, cmd_addb, cmd_data_b,
               cmd_setf, cmd_data_f, ret_dropped, ovf_err
    );
endinterface

// File: rtl/bsv_credit_ctrl.sv
// Credit-pool front end for the BSV load/set/dual-add counter: turns returns, consumes and
// re-init requests into ADDA/ADDB/SETF commands while hiding the two-cycle counter latency.
module bsv_credit_ctrl #(
    parameter int unsigned width         = 8,
    parameter int unsigned init_credits  = 0,
    parameter bit          init_use_port = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    bsv_credit_ctrl_if.slave bus
);
    localparam int unsigned AW = width + 2;
    localparam int unsigned SW = width + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_settle_cnt;
    logic             r_armed;
    logic [width-1:0] r_inflight0;
    logic [width-1:0] r_inflight1;
    logic             r_init_done;
    logic             r_cmd_adda;
    logic [width-1:0] r_cmd_data_a;
    logic             r_cmd_addb;
    logic [width-1:0] r_cmd_data_b;
    logic             r_cmd_setf;
    logic [width-1:0] r_cmd_data_f;
    logic             r_ret_dropped;
    logic             r_ovf_err;

    logic [AW-1:0]    w_avail_raw;
    logic [AW-1:0]    w_avail;
    logic [SW-1:0]    w_ret_sum;
    logic             w_cons_ready;
    logic             w_cons_acc;
    logic             w_cons_cmd;
    logic             w_ret_fwd;
    logic             w_ret_drop;
    logic             w_ovf;
    logic             w_init_entry;
    logic [width-1:0] w_init_val;

    // Next state plus the combinational view of credit availability and request handling
    always_comb begin
        w_state_nxt  = r_state;
        w_avail_raw  = AW'(bus.count_in) - AW'(r_inflight0) - AW'(r_inflight1);
        w_avail      = w_avail_raw[AW-1] ? '0 : w_avail_raw;
        w_cons_ready = 1'b0;
        w_ret_sum    = SW'(bus.count_in) + SW'(bus.ret_amount);
        w_init_val   = init_use_port ? bus.init_value : width'(init_credits);

        case (r_state)
            S_IDLE:   if (bus.init_req) w_state_nxt = S_INIT;
            S_INIT:   w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle_cnt) w_state_nxt = S_RUN;
            S_RUN: begin
                w_cons_ready = !bus.init_req && (w_avail >= AW'(bus.cons_amount));
                if (bus.init_req && r_armed) w_state_nxt = S_DRAIN;
            end
            S_DRAIN:  if ((r_inflight0 == '0) && (r_inflight1 == '0)) w_state_nxt = S_INIT;
            default:  w_state_nxt = S_IDLE;
        endcase

        w_init_entry = (w_state_nxt == S_INIT);
        w_cons_acc   = bus.cons_valid && w_cons_ready;
        w_cons_cmd   = w_cons_acc && (bus.cons_amount != '0);
        // SETF wins inside the counter, so a return landing alongside it would be lost silently
        w_ret_fwd    = bus.ret_valid && (r_state != S_IDLE) && (r_state != S_INIT) && !w_init_entry;
        w_ret_drop   = bus.ret_valid && !w_ret_fwd;
        w_ovf        = w_ret_fwd && w_ret_sum[SW-1];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered commands, in-flight consume pipeline and status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_settle_cnt  <= 1'b0;
            r_armed       <= 1'b0;
            r_inflight0   <= '0;
            r_inflight1   <= '0;
            r_init_done   <= 1'b0;
            r_cmd_adda    <= 1'b0;
            r_cmd_data_a  <= '0;
            r_cmd_addb    <= 1'b0;
            r_cmd_data_b  <= '0;
            r_cmd_setf    <= 1'b0;
            r_cmd_data_f  <= '0;
            r_ret_dropped <= 1'b0;
            r_ovf_err     <= 1'b0;
        end else begin
            r_settle_cnt  <= (r_state == S_SETTLE) && !r_settle_cnt;
            if (w_init_entry) begin
                r_armed <= 1'b0;
            end else if ((r_state == S_RUN) && !bus.init_req) begin
                r_armed <= 1'b1;
            end
            r_inflight0   <= w_cons_acc ? bus.cons_amount : '0;
            r_inflight1   <= r_inflight0;
            r_init_done   <= (w_state_nxt == S_RUN);
            r_cmd_adda    <= w_ret_fwd;
            r_cmd_data_a  <= w_ret_fwd ? bus.ret_amount : '0;
            r_cmd_addb    <= w_cons_cmd;
            r_cmd_data_b  <= w_cons_cmd ? (width'(0) - bus.cons_amount) : '0;
            r_cmd_setf    <= w_init_entry;
            r_cmd_data_f  <= w_init_entry ? w_init_val : '0;
            r_ret_dropped <= w_ret_drop;
            r_ovf_err     <= w_init_entry ? 1'b0 : (r_ovf_err | w_ovf);
        end
    end

    assign bus.init_done   = r_init_done;
    assign bus.cons_ready  = w_cons_ready;
    assign bus.cmd_adda    = r_cmd_adda;
    assign bus.cmd_data_a  = r_cmd_data_a;
    assign bus.cmd_addb    = r_cmd_addb;
    assign bus.cmd_data_b  = r_cmd_data_b;
    assign bus.cmd_setf    = r_cmd_setf;
    assign bus.cmd_data_f  = r_cmd_data_f;
    assign bus.ret_dropped = r_ret_dropped;
    assign bus.ovf_err     = r_ovf_err;
endmodule

// File: tb/tb_bsv_credit_ctrl.sv
// Bench for bsv_credit_ctrl: models the downstream counter and scoreboards the command stream
// against hand-computed expectations, with direct checks of ready/done/overflow status.
module tb_bsv_credit_ctrl;
    typedef struct packed {
        logic       setf;
        logic [7:0] df;
        logic       adda;
        logic [7:0] da;
        logic       addb;
        logic [7:0] db;
        logic       drop;
    } cmd_t;

    typedef struct {
        int   cyc;
        cmd_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] cnt;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    exp_t q[$];

    bsv_credit_ctrl_if #(.width(8)) bus();

    bsv_credit_ctrl #(
        .width(8),
        .init_credits(10),
        .init_use_port(1'b0)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counter model: SETF has priority, otherwise both adders sum
    always @(posedge clk) begin
        if (rst) cnt <= 8'd0;
        else if (bus.cmd_setf) cnt <= bus.cmd_data_f;
        else cnt <= cnt + (bus.cmd_adda ? bus.cmd_data_a : 8'd0) + (bus.cmd_addb ? bus.cmd_data_b : 8'd0);
    end
    assign bus.count_in = cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic ir, input logic rv, input logic [7:0] ra,
                         input logic cv, input logic [7:0] ca);
        bus.init_req    = ir;
        bus.init_value  = 8'd0;
        bus.ret_valid   = rv;
        bus.ret_amount  = ra;
        bus.cons_valid  = cv;
        bus.cons_amount = ca;
    endtask

    task automatic push(input logic setf, input logic [7:0] df, input logic adda, input logic [7:0] da,
                        input logic addb, input logic [7:0] db, input logic drop);
        exp_t e;
        e.cyc    = cyc + 1;
        e.v.setf = setf;
        e.v.df   = df;
        e.v.adda = adda;
        e.v.da   = da;
        e.v.addb = addb;
        e.v.db   = db;
        e.v.drop = drop;
        q.push_back(e);
    endtask

    // Monitor: whenever a command or drop pulse is presented, match it against the scoreboard
    always @(negedge clk) begin
        cmd_t obs;
        exp_t e;
        if (!rst && (bus.cmd_setf || bus.cmd_adda || bus.cmd_addb || bus.ret_dropped)) begin
            obs.setf = bus.cmd_setf;
            obs.df   = bus.cmd_setf ? bus.cmd_data_f : 8'd0;
            obs.adda = bus.cmd_adda;
            obs.da   = bus.cmd_adda ? bus.cmd_data_a : 8'd0;
            obs.addb = bus.cmd_addb;
            obs.db   = bus.cmd_addb ? bus.cmd_data_b : 8'd0;
            obs.drop = bus.ret_dropped;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL cmd_missing: got nothing at cycle %0d expected %h", e.cyc, e.v);
            end
            n_tests++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL cmd_unexpected: got %h at cycle %0d expected no command", obs, cyc);
            end else begin
                e = q.pop_front();
                if (e.v !== obs) begin
                    n_fail++;
                    $display("FAIL cmd_value: got %h expected %h (cycle %0d)", obs, e.v, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        drive(0, 0, 8'd0, 0, 8'd0);
        tick(); tick();
        neg();
        check("rst_init_done", bus.init_done, 0);
        check("rst_cons_ready", bus.cons_ready, 0);
        check("rst_setf", bus.cmd_setf, 0);
        check("rst_adda", bus.cmd_adda, 0);
        check("rst_addb", bus.cmd_addb, 0);
        check("rst_ovf", bus.ovf_err, 0);
        tick();
        rst = 1'b0;

        // Initialise: one SETF of 10, return during INIT dropped, done 3 cycles later
        drive(1, 0, 8'd0, 0, 8'd0); push(1, 8'd10, 0, 8'd0, 0, 8'd0, 0);
        neg(); check("idle_done", bus.init_done, 0); tick();
        drive(0, 1, 8'd7, 0, 8'd0); push(0, 8'd0, 0, 8'd0, 0, 8'd0, 1);
        neg(); check("init_done_lo", bus.init_done, 0); tick();
        drive(0, 0, 8'd0, 0, 8'd0);
        neg(); check("settle1_done", bus.init_done, 0); tick();
        neg(); check("settle2_done", bus.init_done, 0); tick();

        // Back-to-back consumes of 4 from 10
        drive(0, 0, 8'd0, 1, 8'd4); push(0, 8'd0, 0, 8'd0, 1, 8'hFC, 0);
        neg(); check("run_done", bus.init_done, 1); check("count_10", bus.count_in, 10);
        check("cons1_ready", bus.cons_ready, 1); tick();
        push(0, 8'd0, 0, 8'd0, 1, 8'hFC, 0);
        neg(); check("cons2_ready", bus.cons_ready, 1); tick();
        neg(); check("cons3_ready", bus.cons_ready, 0); tick();
        drive(0, 0, 8'd0, 0, 8'd4);
        neg(); check("cons4_ready", bus.cons_ready, 0); check("count_2", bus.count_in, 2); tick();

        // Equality boundary, then a return not yet visible does not raise availability
        drive(0, 1, 8'd8, 0, 8'd2); push(0, 8'd0, 1, 8'd8, 0, 8'd0, 0);
        neg(); check("avail_eq_ready", bus.cons_ready, 1); tick();
        drive(0, 0, 8'd0, 0, 8'd3);
        neg(); check("ret_not_visible", bus.cons_ready, 0); tick();

        // Return 5 and consume 3 together
        drive(0, 1, 8'd5, 1, 8'd3); push(0, 8'd0, 1, 8'h05, 1, 8'hFD, 0);
        neg(); check("count_back_10", bus.count_in, 10); check("mix_ready", bus.cons_ready, 1); tick();
        drive(0, 0, 8'd0, 0, 8'd0);
        neg(); tick();
        drive(0, 0, 8'd0, 1, 8'd0);
        neg(); check("count_12", bus.count_in, 12); check("zero_cons_ready", bus.cons_ready, 1); tick();

        // Overflow: 12+238 = 250, then +10 wraps
        drive(0, 1, 8'd238, 0, 8'd0); push(0, 8'd0, 1, 8'hEE, 0, 8'd0, 0);
        neg(); tick();
        drive(0, 0, 8'd0, 0, 8'd0);
        neg(); tick();
        drive(0, 1, 8'd10, 0, 8'd0); push(0, 8'd0, 1, 8'h0A, 0, 8'd0, 0);
        neg(); check("count_250", bus.count_in, 250); check("ovf_before", bus.ovf_err, 0); tick();
        drive(0, 0, 8'd0, 0, 8'd0);
        neg(); check("ovf_set", bus.ovf_err, 1); tick();

        // Consume then re-init: two DRAIN cycles, one INIT, ovf cleared
        drive(0, 0, 8'd0, 1, 8'd4); push(0, 8'd0, 0, 8'd0, 1, 8'hFC, 0);
        neg(); check("count_wrap_4", bus.count_in, 4); check("ovf_sticky", bus.ovf_err, 1);
        check("cons_last_ready", bus.cons_ready, 1); tick();
        drive(1, 0, 8'd0, 1, 8'd1);
        neg(); check("req_blocks_ready", bus.cons_ready, 0); check("run_before_drain", bus.init_done, 1); tick();
        neg(); check("drain1_done", bus.init_done, 0); check("drain1_ready", bus.cons_ready, 0); tick();
        push(1, 8'd10, 0, 8'd0, 0, 8'd0, 0);
        neg(); check("drain2_ovf", bus.ovf_err, 1); tick();
        neg(); check("init_ovf_clr", bus.ovf_err, 0); tick();
        neg(); tick();
        neg(); tick();
        neg(); check("reinit_count", bus.count_in, 10);
        for (int i = 0; i < 4; i++) begin
            check("held_req_single_init", bus.init_done, 1);
            tick(); neg();
        end
        tick();

        // Reset in the middle of DRAIN
        drive(0, 0, 8'd0, 1, 8'd5); push(0, 8'd0, 0, 8'd0, 1, 8'hFB, 0);
        neg(); check("pre_drain_ready", bus.cons_ready, 1); tick();
        drive(1, 0, 8'd0, 0, 8'd0);
        neg(); tick();
        rst = 1'b1;
        drive(1, 1, 8'd3, 0, 8'd0);
        neg(); check("drain_done_lo", bus.init_done, 0); tick();
        neg();
        check("mid_rst_done", bus.init_done, 0);
        check("mid_rst_ready", bus.cons_ready, 0);
        check("mid_rst_setf", bus.cmd_setf, 0);
        check("mid_rst_adda", bus.cmd_adda, 0);
        check("mid_rst_data_a", bus.cmd_data_a, 0);
        check("mid_rst_addb", bus.cmd_addb, 0);
        check("mid_rst_drop", bus.ret_dropped, 0);
        check("mid_rst_ovf", bus.ovf_err, 0);
        tick();
        rst = 1'b0;
        drive(0, 1, 8'd2, 0, 8'd0); push(0, 8'd0, 0, 8'd0, 0, 8'd0, 1);
        neg(); tick();
        drive(0, 0, 8'd0, 0, 8'd0);
        neg(); check("idle_after_rst", bus.init_done, 0); tick();
        tick();

        while (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL cmd_missing: got nothing at cycle %0d expected %h", e.cyc, e.v);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
